// File: rtl/mem_access_unit_if.sv
// Load/store request, completion and data-bus signals of the memory access unit.
// The slave modport is the unit's view; the master modport is the decode/memory side.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wbmask;
    logic        req_sign;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wbmask, req_sign,
        input  mem_ready, mem_rvalid, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wbmask, req_sign,
        output mem_ready, mem_rvalid, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store engine: lane steering, load extension,
// alignment checking and a REQ/WAIT timeout on the word-wide data bus.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic              clock,
    input logic              reset_n,
    mem_access_unit_if.slave bus
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_we;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic [3:0]    r_mem_wstrb;
    logic [1:0]    r_lane;
    logic [3:0]    r_mask;
    logic          r_sign;
    logic [31:0]   r_rdata;
    logic          r_err;

    logic          w_accept;
    logic          w_legal;
    logic          w_timeout;
    logic [31:0]   w_shifted;
    logic [31:0]   w_load_data;

    assign w_accept  = bus.req_valid && (r_state == S_IDLE);
    // The counter saturates at the last allowed cycle, so a ready that wins
    // the final REQ cycle leaves the load exactly one WAIT cycle for its data.
    assign w_timeout = (r_cnt >= CW'(TIMEOUT_CYCLES - 1));
    assign w_shifted = bus.mem_rdata >> {r_lane, 3'b000};

    // NOTE: every always_comb output is assigned a default first so no path can infer a latch.
    always_comb begin
        w_legal = 1'b0;
        case (bus.req_wbmask)
            4'b0001: w_legal = 1'b1;
            4'b0011: w_legal = ~bus.req_addr[0];
            4'b1111: w_legal = (bus.req_addr[1:0] == 2'b00);
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_load_data = w_shifted;
        case (r_mask)
            4'b0001: w_load_data = {{24{r_sign & w_shifted[7]}},  w_shifted[7:0]};
            4'b0011: w_load_data = {{16{r_sign & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_lane      <= '0;
            r_mask      <= '0;
            r_sign      <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt       <= '0;
                        r_we        <= bus.req_we;
                        r_mem_addr  <= {bus.req_addr[31:2], 2'b00};
                        r_mem_wdata <= bus.req_wdata << {bus.req_addr[1:0], 3'b000};
                        r_mem_wstrb <= bus.req_we ? (bus.req_wbmask << bus.req_addr[1:0]) : 4'b0000;
                        r_lane      <= bus.req_addr[1:0];
                        r_mask      <= bus.req_wbmask;
                        r_sign      <= bus.req_sign;
                        r_rdata     <= '0;
                        r_err       <= ~w_legal;
                        r_state     <= w_legal ? S_REQ : S_RESP;
                    end
                end
                S_REQ: begin
                    if (!w_timeout) r_cnt <= r_cnt + 1'b1;
                    if (bus.mem_ready) begin
                        r_state <= r_we ? S_RESP : S_WAIT;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end
                end
                S_WAIT: begin
                    if (!w_timeout) r_cnt <= r_cnt + 1'b1;
                    if (bus.mem_rvalid) begin
                        r_rdata <= w_load_data;
                        r_state <= S_RESP;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;
    assign bus.mem_valid  = (r_state == S_REQ);
    assign bus.mem_we     = r_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.mem_wstrb  = r_mem_wstrb;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised bench for mem_access_unit: requests push expected responses into a
// queue that an independent monitor pops whenever resp_valid is seen.
module tb_mem_access_unit;

    localparam int T = 6;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    mem_access_unit_if bus ();

    mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor, independent of the stimulus process.
    always @(negedge clock) begin
        exp_t e;
        if (reset_n && bus.resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_resp: got resp_valid=1 required no response (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                check("resp_rdata", bus.resp_rdata, e.rdata);
                check("resp_err", {31'b0, bus.resp_err}, {31'b0, e.err});
                check("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    function automatic logic [31:0] load_value(input logic [31:0] word, input int lane,
                                                input logic [3:0] mask, input bit sign);
        logic [31:0] sh;
        logic [31:0] v;
        sh = word >> (8 * lane);
        if (mask == 4'b0001) begin
            v = sh % 256;
            if (sign && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (mask == 4'b0011) begin
            v = sh % 65536;
            if (sign && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic bit is_legal(input logic [31:0] addr, input logic [3:0] mask);
        return (mask == 4'b0001) ||
               (mask == 4'b0011 && addr % 2 == 0) ||
               (mask == 4'b1111 && addr % 4 == 0);
    endfunction

    task automatic wait_idle(input string name);
        int g;
        g = 0;
        while (bus.req_ready !== 1'b1 && g < 20) begin
            @(negedge clock);
            g++;
        end
        if (g == 20) check(name, {31'b0, bus.req_ready}, 32'd1);
    endtask

    // d: REQ cycles before mem_ready; w: WAIT cycles before mem_rvalid (loads).
    task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] mask, input bit sign, input logic [31:0] word,
                           input int d, input int w);
        bit   legal;
        bit   timeout;
        int   lane;
        int   last;
        int   end_k;
        int   r;
        int   lim;
        int   held;
        exp_t e;

        lane    = int'(addr % 4);
        legal   = is_legal(addr, mask);
        last    = T - 1;
        r       = d + 1 + w;
        timeout = 1'b0;
        held    = 0;
        if (d > last) begin
            timeout = 1'b1;
            end_k   = last;
        end else if (we) begin
            end_k = d;
        end else begin
            lim = (last > d + 1) ? last : d + 1;
            if (r <= lim) end_k = r;
            else begin
                timeout = 1'b1;
                end_k   = lim;
            end
        end

        e.err   = !legal || timeout;
        e.rdata = (!legal || timeout || we) ? 32'h0 : load_value(word, lane, mask, sign);
        e.lat   = legal ? end_k + 2 : 1;

        @(negedge clock);
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_wbmask = mask;
        bus.req_sign   = sign;
        bus.req_valid  = 1'b1;
        wait_idle("req_ready_timeout");
        e.acc = cyc;
        @(posedge clock);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_addr   = $urandom();
        bus.req_wdata  = $urandom();
        bus.req_wbmask = 4'($urandom());
        bus.req_we     = 1'($urandom());
        bus.req_sign   = 1'($urandom());
        exp_q.push_back(e);

        if (!legal) begin
            repeat (3) begin
                @(negedge clock);
                if (bus.mem_valid === 1'b1) held++;
            end
            check("illegal_no_bus", 32'(held), 32'd0);
        end else begin
            for (int k = 0; k <= end_k; k++) begin
                @(negedge clock);
                if (bus.mem_valid === 1'b1) held++;
                if (k == 0) begin
                    check("mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
                    check("mem_we", {31'b0, bus.mem_we}, {31'b0, we});
                    check("mem_wstrb", {28'b0, bus.mem_wstrb},
                          we ? 32'(mask) * (32'd1 << lane) : 32'd0);
                    if (we) check("mem_wdata", bus.mem_wdata, wdata << (8 * lane));
                end
                bus.mem_ready  = (k == d);
                bus.mem_rvalid = (!we && k == r && k > d);
                bus.mem_rdata  = bus.mem_rvalid ? word : $urandom();
            end
            @(negedge clock);
            bus.mem_ready  = 1'b0;
            bus.mem_rvalid = !we;
            bus.mem_rdata  = $urandom();
            check("mem_valid_cycles", 32'(held), 32'(((d < end_k) ? d : end_k) + 1));
        end
        @(negedge clock);
        bus.mem_rvalid = 1'b0;
        wait_idle("idle_timeout");
    endtask

    task automatic reset_mid(input bit in_wait);
        @(negedge clock);
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'h0000_0040;
        bus.req_wbmask = 4'b1111;
        bus.req_sign   = 1'b0;
        bus.req_valid  = 1'b1;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clock);
        check("mid_mem_valid", {31'b0, bus.mem_valid}, 32'd1);
        if (in_wait) begin
            bus.mem_ready = 1'b1;
            @(posedge clock);
            #1;
            bus.mem_ready = 1'b0;
            @(negedge clock);
        end
        reset_n = 1'b0;
        #1;
        check("rst_mem_valid", {31'b0, bus.mem_valid}, 32'd0);
        check("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wstrb", {28'b0, bus.mem_wstrb}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = $urandom();
        @(negedge clock);
        bus.mem_rvalid = 1'b0;
        repeat (3) @(negedge clock);
        check("post_rst_idle", {31'b0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit          we;
        logic [31:0] addr;
        logic [3:0]  mask;
        int          sel;

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_wbmask = '0;
        bus.req_sign   = 1'b0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;

        repeat (2) @(negedge clock);
        check("reset_req_ready", {31'b0, bus.req_ready}, 32'd1);
        check("reset_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        check("reset_resp_rdata", bus.resp_rdata, 32'd0);
        check("reset_resp_err", {31'b0, bus.resp_err}, 32'd0);
        check("reset_mem_valid", {31'b0, bus.mem_valid}, 32'd0);
        check("reset_mem_we", {31'b0, bus.mem_we}, 32'd0);
        check("reset_mem_addr", bus.mem_addr, 32'd0);
        check("reset_mem_wdata", bus.mem_wdata, 32'd0);
        check("reset_mem_wstrb", {28'b0, bus.mem_wstrb}, 32'd0);
        reset_n = 1'b1;

        run_txn(1'b1, 32'h0000_1003, 32'h0000_00AB, 4'b0001, 1'b0, 32'h0, 0, 0);
        run_txn(1'b0, 32'h0000_1002, 32'h0, 4'b0001, 1'b1, 32'h0080_0000, 0, 0);
        run_txn(1'b0, 32'h0000_1002, 32'h0, 4'b0001, 1'b0, 32'h0080_0000, 1, 1);
        run_txn(1'b0, 32'h0000_2002, 32'h0, 4'b0011, 1'b1, 32'h8001_0000, 3, 0);
        run_txn(1'b0, 32'h0000_1001, 32'h0, 4'b1111, 1'b0, 32'h0, 0, 0);
        run_txn(1'b1, 32'h0000_1000, 32'h1234_5678, 4'b0000, 1'b0, 32'h0, 0, 0);
        run_txn(1'b1, 32'h0000_1001, 32'h0000_BEEF, 4'b0011, 1'b0, 32'h0, 0, 0);
        run_txn(1'b1, 32'h0000_3000, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0, 100, 0);
        run_txn(1'b0, 32'h0000_3004, 32'h0, 4'b1111, 1'b1, 32'hCAFE_F00D, 100, 0);
        run_txn(1'b0, 32'h0000_3004, 32'h0, 4'b1111, 1'b1, 32'h8765_4321, 2, 9);
        run_txn(1'b1, 32'h0000_3008, 32'hA5A5_5A5A, 4'b1111, 1'b0, 32'h0, T - 1, 0);
        run_txn(1'b0, 32'h0000_3001, 32'h0, 4'b0001, 1'b1, 32'h0000_F100, T - 1, 0);
        run_txn(1'b0, 32'h0000_3001, 32'h0, 4'b0001, 1'b1, 32'h0000_F100, T - 1, 1);
        run_txn(1'b0, 32'h0000_3000, 32'h0, 4'b0011, 1'b0, 32'h1234_FFFE, 2, T - 4);

        reset_mid(1'b1);
        run_txn(1'b0, 32'h0000_4003, 32'h0, 4'b0001, 1'b1, 32'h7F00_0000, 0, 0);
        reset_mid(1'b0);
        run_txn(1'b1, 32'h0000_4002, 32'h0000_1234, 4'b0011, 1'b0, 32'h0, 1, 0);

        for (int i = 0; i < 60; i++) begin
            sel  = int'($urandom_range(0, 9));
            mask = (sel < 3) ? 4'b0001 : (sel < 6) ? 4'b0011 : (sel < 9) ? 4'b1111
                                       : 4'($urandom());
            addr = $urandom();
            if ($urandom_range(0, 3) != 0) begin
                if (mask == 4'b0011) addr[0] = 1'b0;
                if (mask == 4'b1111) addr[1:0] = 2'b00;
            end
            we = 1'($urandom());
            run_txn(we, addr, $urandom(), mask, 1'($urandom()), $urandom(),
                    int'($urandom_range(0, T)), int'($urandom_range(0, 3)));
        end

        repeat (4) @(negedge clock);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
